// File: rtl/tristate_frame_enc.sv
// PT2262-style tri-state frame encoder: NBITS code symbols plus a sync bit per frame,
// with each frame sent REPEAT times. Sub-ticks are TICK_DIV clocks long. q, busy and done are registered.
module tristate_frame_enc #(
  parameter int NBITS    = 12,
  parameter int TICK_DIV = 1,
  parameter int REPEAT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*NBITS-1:0] data,
  output logic               q,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int REP_W = $clog2(REPEAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CODE = 2'd1, SYNC = 2'd2} state_t;

  state_t             state, nxt_state;
  logic [2*NBITS-1:0] word, nxt_word;
  logic [2*NBITS-1:0] sr, nxt_sr;
  logic [DIV_W-1:0]   div_cnt, nxt_div;
  logic [6:0]         sub_cnt, nxt_sub;
  logic [BIT_W-1:0]   bit_idx, nxt_bit;
  logic [REP_W-1:0]   rep_cnt, nxt_rep, rep_inc;
  logic               nxt_q, nxt_done, tick_end;

  // Each 16-sub-tick half of a code bit is either short-high (H4 L12) or long-high (H12 L4).
  // A 0 is short/short, a 1 is long/long, and an F is short then long.
  function automatic logic code_level(input logic [1:0] sym, input logic [4:0] t);
    logic long_half;
    long_half = (sym == 2'b01) | (sym[1] & t[4]);
    return long_half ? (t[3:0] < 4'd12) : (t[3:0] < 4'd4);
  endfunction

  assign rep_inc = rep_cnt + 1'b1;

  always_comb begin
    nxt_state = state;
    nxt_word  = word;
    nxt_sr    = sr;
    nxt_div   = div_cnt;
    nxt_sub   = sub_cnt;
    nxt_bit   = bit_idx;
    nxt_rep   = rep_cnt;
    nxt_done  = 1'b0;
    tick_end  = (div_cnt == DIV_W'(TICK_DIV - 1));
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = CODE;
          nxt_word  = data;
          nxt_sr    = data;
          nxt_div   = '0;
          nxt_sub   = '0;
          nxt_bit   = '0;
          nxt_rep   = '0;
        end
      end
      CODE: begin
        if (!tick_end) begin
          nxt_div = div_cnt + 1'b1;
        end else begin
          nxt_div = '0;
          if (sub_cnt == 7'd31) begin
            nxt_sub = '0;
            nxt_sr  = sr << 2;
            if (bit_idx == BIT_W'(NBITS - 1)) begin
              nxt_state = SYNC;
              nxt_bit   = '0;
            end else begin
              nxt_bit = bit_idx + 1'b1;
            end
          end else begin
            nxt_sub = sub_cnt + 1'b1;
          end
        end
      end
      SYNC: begin
        if (!tick_end) begin
          nxt_div = div_cnt + 1'b1;
        end else begin
          nxt_div = '0;
          if (sub_cnt == 7'd127) begin
            nxt_sub = '0;
            if (rep_inc < REP_W'(REPEAT)) begin
              nxt_state = CODE;
              nxt_rep   = rep_inc;
              nxt_sr    = word;
            end else begin
              nxt_state = IDLE;
              nxt_rep   = '0;
              nxt_done  = 1'b1;
            end
          end else begin
            nxt_sub = sub_cnt + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    // q is the level of the position the counters move to, so it lines up with them after the edge.
    case (nxt_state)
      CODE:    nxt_q = code_level(nxt_sr[2*NBITS-1 -: 2], nxt_sub[4:0]);
      SYNC:    nxt_q = (nxt_sub < 7'd4);
      default: nxt_q = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      sr      <= '0;
      div_cnt <= '0;
      sub_cnt <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      q       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      word    <= nxt_word;
      sr      <= nxt_sr;
      div_cnt <= nxt_div;
      sub_cnt <= nxt_sub;
      bit_idx <= nxt_bit;
      rep_cnt <= nxt_rep;
      q       <= nxt_q;
      busy    <= (nxt_state != IDLE);
      done    <= nxt_done;
    end
  end

  assign state_dbg = state;

endmodule
